// File: rtl/prf_wr_arbiter.sv
// prf_wr_arbiter: per-bank writeback arbiter in front of a banked PRF.
// Round-robin with PRF_WR_ARB_RR_EN defined, fixed priority otherwise.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   wr_req_valid_by_port      request valid per port
//   wr_req_PR_by_port         destination PR; PR[1:0] selects the bank
//   wr_req_data_by_port       write data per port
//   wr_req_ready_by_port      same-cycle acceptance per port
//   bank_wr_valid_by_bank     registered write enable per bank
//   bank_wr_upper_PR_by_bank  registered in-bank index PR[LOG_PR_COUNT-1:2]
//   bank_wr_data_by_bank      registered write data per bank
//   bank_wr_port_by_bank      registered granted port index per bank
module prf_wr_arbiter #(
  parameter int PRF_WR_COUNT   = 8,
  parameter int PRF_BANK_COUNT = 4,
  parameter int LOG_PR_COUNT   = 7,
  parameter int XLEN           = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic [PRF_WR_COUNT-1:0] wr_req_valid_by_port,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]
    wr_req_PR_by_port,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]
    wr_req_data_by_port,
  output logic [PRF_WR_COUNT-1:0] wr_req_ready_by_port,
  output logic [PRF_BANK_COUNT-1:0] bank_wr_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-3:0]
    bank_wr_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]
    bank_wr_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][2:0]
    bank_wr_port_by_bank
);

  logic [PRF_BANK_COUNT-1:0]      grant;
  logic [PRF_BANK_COUNT-1:0][2:0] sel;
  int                             idx;

`ifdef PRF_WR_ARB_RR_EN
  logic [PRF_BANK_COUNT-1:0][2:0] ptr;
`endif

  // PR 0 is the hardwired zero register: it is acked
  // without occupying the bank-0 write slot.
  always_comb begin
    grant = '0;
    sel   = '0;
    idx   = 0;
    wr_req_ready_by_port = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
`ifdef PRF_WR_ARB_RR_EN
        idx = int'(ptr[b]) + k;
        if (idx >= PRF_WR_COUNT)
          idx = idx - PRF_WR_COUNT;
`else
        idx = k;
`endif
        if (!grant[b] &&
            wr_req_valid_by_port[idx] &&
            (wr_req_PR_by_port[idx] != '0) &&
            (wr_req_PR_by_port[idx][1:0] == 2'(b))) begin
          grant[b] = 1'b1;
          sel[b]   = 3'(idx);
        end
      end
    end
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (wr_req_valid_by_port[i] &&
          (wr_req_PR_by_port[i] == '0))
        wr_req_ready_by_port[i] = 1'b1;
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (grant[b])
        wr_req_ready_by_port[sel[b]] = 1'b1;
    end
    if (RST)
      wr_req_ready_by_port = '0;
  end

  always_ff @(posedge CLK) begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (RST || !grant[b]) begin
        bank_wr_valid_by_bank[b]    <= 1'b0;
        bank_wr_upper_PR_by_bank[b] <= '0;
        bank_wr_data_by_bank[b]     <= '0;
        bank_wr_port_by_bank[b]     <= '0;
      end else begin
        bank_wr_valid_by_bank[b]    <= 1'b1;
        bank_wr_upper_PR_by_bank[b] <=
          wr_req_PR_by_port[sel[b]][LOG_PR_COUNT-1:2];
        bank_wr_data_by_bank[b]     <=
          wr_req_data_by_port[sel[b]];
        bank_wr_port_by_bank[b]     <= sel[b];
      end
    end
  end

`ifdef PRF_WR_ARB_RR_EN
  // Pointer moves just past the winner so it drops to
  // lowest priority in its bank next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant[b]) begin
          if (sel[b] == 3'(PRF_WR_COUNT-1))
            ptr[b] <= '0;
          else
            ptr[b] <= sel[b] + 3'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// tb_prf_wr_arbiter: randomized + directed scoreboard bench
// for prf_wr_arbiter (either arbitration build).
module tb_prf_wr_arbiter;

  localparam int N = 8;
  localparam int B = 4;

  typedef struct {
    int          due;
    logic [4:0]  upr;
    logic [31:0] data;
    logic [2:0]  port;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]        vld = '0;
  logic [N-1:0][6:0]   prs = '0;
  logic [N-1:0][31:0]  dat = '0;
  logic [N-1:0]        rdy;
  logic [B-1:0]        bv;
  logic [B-1:0][4:0]   bu;
  logic [B-1:0][31:0]  bd;
  logic [B-1:0][2:0]   bp;

  int   vectors = 0;
  int   errors  = 0;
  int   edge_cnt = 0;
  bit   mon_en = 0;
  exp_t sb [B][$];
  int   ptr_m [B];

  logic [N-1:0]       tv;
  logic [N-1:0][6:0]  tp;
  logic [N-1:0][31:0] td;
  logic [N-1:0]       er;

  prf_wr_arbiter dut (
    .CLK(clk),
    .RST(rst),
    .wr_req_valid_by_port(vld),
    .wr_req_PR_by_port(prs),
    .wr_req_data_by_port(dat),
    .wr_req_ready_by_port(rdy),
    .bank_wr_valid_by_bank(bv),
    .bank_wr_upper_PR_by_bank(bu),
    .bank_wr_data_by_bank(bd),
    .bank_wr_port_by_bank(bp)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Reference: each bank takes the first eligible port in
  // search order; PR0 is acked for free; reset acks nothing.
  task automatic model(input logic r,
                       input logic [N-1:0] v,
                       input logic [N-1:0][6:0] p,
                       input logic [N-1:0][31:0] d,
                       output logic [N-1:0] exp_rdy);
    exp_t e;
    exp_rdy = '0;
    if (r) begin
      for (int b = 0; b < B; b++) ptr_m[b] = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (v[i] && p[i] == 7'd0) exp_rdy[i] = 1'b1;
    for (int b = 0; b < B; b++) begin
      bit found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
`ifdef PRF_WR_ARB_RR_EN
        i = (ptr_m[b] + k) % N;
`else
        i = k;
`endif
        if (!found && v[i] && p[i] != 7'd0 &&
            int'(p[i][1:0]) == b) begin
          found = 1;
          exp_rdy[i] = 1'b1;
          e.due  = edge_cnt + 1;
          e.upr  = p[i][6:2];
          e.data = d[i];
          e.port = 3'(i);
          sb[b].push_back(e);
          ptr_m[b] = (i + 1) % N;
        end
      end
    end
  endtask

  task automatic cyc(input logic r,
                     input logic [N-1:0] v,
                     input logic [N-1:0][6:0] p,
                     input logic [N-1:0][31:0] d,
                     output logic [N-1:0] exp_rdy);
    @(posedge clk);
    #1;
    rst = r; vld = v; prs = p; dat = d;
    #1;
    model(r, v, p, d, exp_rdy);
    vectors++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL ready t=%0d got=%h exp=%h",
               edge_cnt, rdy, exp_rdy);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int b = 0; b < B; b++) begin
        exp_t e;
        vectors++;
        if (bv[b] === 1'b1) begin
          if (sb[b].size() == 0) begin
            errors++;
            $display("FAIL bank%0d unexpected write t=%0d",
                     b, edge_cnt);
          end else begin
            e = sb[b].pop_front();
            if (e.due != edge_cnt || bu[b] !== e.upr ||
                bd[b] !== e.data || bp[b] !== e.port) begin
              errors++;
              $display({"FAIL bank%0d write t=%0d got ",
                        "upr=%0d d=%h p=%0d exp t=%0d ",
                        "upr=%0d d=%h p=%0d"},
                       b, edge_cnt, bu[b], bd[b], bp[b],
                       e.due, e.upr, e.data, e.port);
            end
          end
        end else begin
          if (bv[b] !== 1'b0 || bu[b] !== '0 ||
              bd[b] !== '0 || bp[b] !== '0) begin
            errors++;
            $display("FAIL bank%0d idle got v=%b u=%h d=%h p=%h",
                     b, bv[b], bu[b], bd[b], bp[b]);
          end
          while (sb[b].size() > 0 &&
                 sb[b][0].due <= edge_cnt) begin
            e = sb[b].pop_front();
            errors++;
            $display("FAIL bank%0d missing write due=%0d p=%0d",
                     b, e.due, e.port);
          end
        end
      end
    end
  end

  logic [N-1:0]       pv;
  logic [N-1:0][6:0]  pp;
  logic [N-1:0][31:0] pd;

  initial begin
    for (int b = 0; b < B; b++) ptr_m[b] = 0;
    tv = '1; tp = '0; td = '0;
    cyc(1'b1, tv, tp, td, er);
    mon_en = 1;
    chk("reset_ready_pr0", rdy, 8'h00);
    cyc(1'b1, '0, '0, '0, er);

    // four banks in parallel
    tv = 8'h0F; tp = '0;
    for (int i = 0; i < 4; i++) begin
      tp[i] = 7'(4 + i); td[i] = 32'hA000_0000 + i;
    end
    cyc(1'b0, tv, tp, td, er);
    chk("four_banks", rdy, 8'h0F);

    // PR0 bypass alongside a bank-0 write
    tv = 8'h24; tp = '0; tp[5] = 7'd16;
    td[2] = 32'h1111_2222; td[5] = 32'h5555_6666;
    cyc(1'b0, tv, tp, td, er);
    chk("pr0_bypass", rdy, 8'h24);

    // two requests to bank 0 after reset
    cyc(1'b1, '0, '0, '0, er);
    tv = 8'h11; tp = '0; tp[0] = 7'd8; tp[4] = 7'd12;
    td[0] = 32'hDEAD_0000; td[4] = 32'hDEAD_0004;
    cyc(1'b0, tv, tp, td, er);
    chk("bank0_first", rdy, 8'h01);
    tv = 8'h10;
    cyc(1'b0, tv, tp, td, er);
    chk("bank0_second", rdy, 8'h10);
    cyc(1'b0, '0, '0, '0, er);

    // all ports held on bank 3
    cyc(1'b1, '0, '0, '0, er);
    tv = '1;
    for (int i = 0; i < N; i++) begin
      tp[i] = 7'(3 + 4 * i); td[i] = 32'hB300_0000 + i;
    end
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, tv, tp, td, er);
`ifdef PRF_WR_ARB_RR_EN
      chk("bank3_rr", rdy, 8'(1 << k));
`else
      chk("bank3_fixed", rdy, 8'h01);
`endif
    end

    // reset while bank1 output is valid
    tv = 8'h0A; tp = '0; tp[1] = 7'd5; tp[3] = 7'd6;
    td[1] = 32'hC1C1_C1C1; td[3] = 32'hC3C3_C3C3;
    cyc(1'b0, tv, tp, td, er);
    tv = 8'hFF; tp = '0; tp[1] = 7'd9;
    cyc(1'b1, tv, tp, td, er);
    chk("ready_in_reset", rdy, 8'h00);
    tv = '1;
    for (int i = 0; i < N; i++) begin
      tp[i] = 7'(2 + 4 * i); td[i] = 32'hE200_0000 + i;
    end
    cyc(1'b0, tv, tp, td, er);
    chk("ptr_restart", rdy, 8'h01);
    cyc(1'b0, '0, '0, '0, er);

    // random traffic; requesters hold until accepted
    pv = '0; pp = '0; pd = '0;
    for (int t = 0; t < 10000; t++) begin
      logic r;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pp[i] = ($urandom_range(0, 7) == 0) ? 7'd0 :
                  7'($urandom_range(0, 127));
          pd[i] = $urandom;
        end
      end
      r = ($urandom_range(0, 399) == 0);
      cyc(r, pv, pp, pd, er);
      for (int i = 0; i < N; i++)
        if (er[i]) pv[i] = 1'b0;
    end

    cyc(1'b0, '0, '0, '0, er);
    cyc(1'b0, '0, '0, '0, er);
    @(posedge clk);
    #2;
    for (int b = 0; b < B; b++) begin
      vectors++;
      if (sb[b].size() != 0) begin
        errors++;
        $display("FAIL drain bank%0d left=%0d exp=0",
                 b, sb[b].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
